// File: rtl/gb_line_fb_feeder.sv
// gb_line_fb_feeder
//   Turns the Game Boy core's 160x144 BGR555 pixel stream into RGB565 word
//   writes for the PSRAM framebuffer write path. Each source pixel is written
//   twice (2x horizontal), addresses run linearly from BASE_ADDR with
//   LINE_WORDS words per row, and one hGBNewLine pulse follows every finished
//   row. Short lines are zero-padded to full width.
//
// Ports
//   hClk          clock, rising edge
//   hReset_n      asynchronous active-low reset
//   hFrameStart   1-cycle pulse, start of frame (aborts any line in progress)
//   hLineStart    1-cycle pulse, start of a source line
//   hPixValid     hPixData valid
//   hPixData      {B[14:10],G[9:5],R[4:0]}
//   hPixReady     pixel accepted when hPixValid & hPixReady
//   hGBNewLine    1-cycle pulse after the last word of a row
//   hGBAddress    word address of current write (held while idle)
//   hGBWrite      write strobe, one word per cycle
//   hGBData       RGB565 {R5,G6,B5} (held while idle)
//   hLineCount    completed rows this frame
//   hOverrun      sticky excess-pixel / excess-line flag, cleared by hFrameStart
module gb_line_fb_feeder #(
   parameter logic [22:0] BASE_ADDR  = 23'h10000,
   parameter int          SRC_WIDTH  = 160,
   parameter int          SRC_HEIGHT = 144,
   parameter int          LINE_WORDS = 320
) (
   input  logic        hClk,
   input  logic        hReset_n,
   input  logic        hFrameStart,
   input  logic        hLineStart,
   input  logic        hPixValid,
   input  logic [14:0] hPixData,
   output logic        hPixReady,
   output logic        hGBNewLine,
   output logic [22:0] hGBAddress,
   output logic        hGBWrite,
   output logic [15:0] hGBData,
   output logic [7:0]  hLineCount,
   output logic        hOverrun
);

   typedef enum logic [2:0] {IDLE, LWAIT, ACT, DUP, PAD, DONE} state_t;

   localparam logic [8:0]  LINE_END = 9'(2 * SRC_WIDTH);
   localparam logic [8:0]  LAST_X   = 9'(2 * SRC_WIDTH - 1);
   localparam logic [7:0]  LAST_Y   = 8'(SRC_HEIGHT);
   localparam logic [22:0] ROW_STEP = 23'(LINE_WORDS);

   state_t      state;
   logic [8:0]  x;          // next framebuffer word within the row
   logic [22:0] row;        // word address of x=0 of the current row
   logic        line_pend;  // hLineStart seen before the current row finished
   logic [2:0]  excess;     // consecutive cycles of hPixValid while waiting for a line

   function automatic logic [15:0] bgr555_to_rgb565(input logic [14:0] p);
      // G gets its MSB replicated into the new LSB so full scale stays full scale.
      return {p[4:0], p[9:5], p[9], p[14:10]};
   endfunction

   always_ff @(posedge hClk or negedge hReset_n) begin
      if (!hReset_n) begin
         state      <= IDLE;
         x          <= '0;
         row        <= BASE_ADDR;
         line_pend  <= 1'b0;
         excess     <= '0;
         hPixReady  <= 1'b0;
         hGBNewLine <= 1'b0;
         hGBAddress <= '0;
         hGBWrite   <= 1'b0;
         hGBData    <= '0;
         hLineCount <= '0;
         hOverrun   <= 1'b0;
      end else begin
         hGBWrite   <= 1'b0;
         hGBNewLine <= 1'b0;
         if (hFrameStart) begin
            // Abort whatever is running; a pending duplicate write is dropped.
            row        <= BASE_ADDR;
            x          <= '0;
            hLineCount <= '0;
            hOverrun   <= 1'b0;
            line_pend  <= 1'b0;
            excess     <= '0;
            if (hLineStart) begin
               state     <= ACT;
               hPixReady <= 1'b1;
            end else begin
               state     <= LWAIT;
               hPixReady <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  hPixReady <= 1'b0;
               end
               LWAIT: begin
                  if (hLineStart) begin
                     excess <= '0;
                     if (hLineCount == LAST_Y) begin
                        hOverrun <= 1'b1;
                     end else begin
                        state     <= ACT;
                        x         <= '0;
                        hPixReady <= 1'b1;
                     end
                  end else if (hPixValid) begin
                     if (excess == 3'd4) hOverrun <= 1'b1;
                     else                excess   <= excess + 3'd1;
                  end else begin
                     excess <= '0;
                  end
               end
               ACT: begin
                  if (hPixValid && hPixReady) begin
                     hGBWrite   <= 1'b1;
                     hGBAddress <= row + 23'(x);
                     hGBData    <= bgr555_to_rgb565(hPixData);
                     hPixReady  <= 1'b0;
                     state      <= DUP;
                     if (hLineStart) line_pend <= 1'b1;
                  end else if (hLineStart) begin
                     hPixReady <= 1'b0;
                     line_pend <= 1'b1;
                     state     <= PAD;
                  end
               end
               DUP: begin
                  // Second copy of the pixel; hGBData still holds it.
                  hGBWrite   <= 1'b1;
                  hGBAddress <= row + 23'(x) + 23'd1;
                  x          <= x + 9'd2;
                  if (hLineStart) line_pend <= 1'b1;
                  if (x + 9'd2 == LINE_END) begin
                     hPixReady <= 1'b0;
                     state     <= DONE;
                  end else if (line_pend || hLineStart) begin
                     hPixReady <= 1'b0;
                     state     <= PAD;
                  end else begin
                     hPixReady <= 1'b1;
                     state     <= ACT;
                  end
               end
               PAD: begin
                  hGBWrite   <= 1'b1;
                  hGBAddress <= row + 23'(x);
                  hGBData    <= 16'h0000;
                  x          <= x + 9'd1;
                  if (hLineStart) line_pend <= 1'b1;
                  if (x == LAST_X) state <= DONE;
               end
               DONE: begin
                  hGBNewLine <= 1'b1;
                  row        <= row + ROW_STEP;
                  hLineCount <= hLineCount + 8'd1;
                  x          <= '0;
                  line_pend  <= 1'b0;
                  excess     <= '0;
                  // A line start that arrived early begins the next row at once.
                  if ((line_pend || hLineStart) && (hLineCount + 8'd1 != LAST_Y)) begin
                     hPixReady <= 1'b1;
                     state     <= ACT;
                  end else begin
                     if (line_pend || hLineStart) hOverrun <= 1'b1;
                     hPixReady <= 1'b0;
                     state     <= LWAIT;
                  end
               end
               default: begin
                  hPixReady <= 1'b0;
                  state     <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
